// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet/IPv4/UDP constants, CRC-32 constants and receive state type
package eth_pkg;
  localparam logic [15:0] ETH_HDR_LEN = 16'd14;
  localparam logic [15:0] IP_HDR_LEN = 16'd20;
  localparam logic [15:0] UDP_HDR_LEN = 16'd8;
  localparam logic [15:0] HDR_TOTAL = 16'd42;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;
  typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, TAIL, CHECK, DROP} rx_state_t;
endpackage

// File: rtl/eth_crc32_nibble.sv
// eth_crc32_nibble: next CRC-32 register value after four data bits, bit 0 first
// ports: crc_i current register, data_i MII nibble, crc_o updated register
module eth_crc32_nibble
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [3:0]  data_i,
  output logic [31:0] crc_o
);
  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 4; i++)
      crc_o = {crc_o[30:0], 1'b0} ^ ((crc_o[31] ^ data_i[i]) ? CRC32_POLY : 32'h0);
  end
endmodule

// File: rtl/eth_udprx.sv
// eth_udprx: MII receiver that filters Ethernet/IPv4/UDP frames and streams the UDP payload
// ports: eth_rx_* MII receive pins (eth_rx_clk is the only clock, reset_n async active-low);
//        cfg_* local MAC/IP/port filters; usr_* payload stream, sender info and per-frame
//        good/bad verdict; stat_drop_o saturating count of frames dropped before payload
module eth_udprx
  import eth_pkg::*;
#(
  parameter int MAX_PAYLOAD  = 1472,
  parameter bit ACCEPT_BCAST = 1'b1
) (
  input  logic        eth_rx_clk,
  input  logic        reset_n,
  input  logic [3:0]  eth_rx_data,
  input  logic        eth_rx_dv,
  input  logic        eth_rx_er,
  input  logic [47:0] cfg_ethaddr_i,
  input  logic [31:0] cfg_ipaddr_i,
  input  logic [15:0] cfg_udpport_i,
  output logic [7:0]  usr_data_o,
  output logic        usr_valid_o,
  output logic        usr_sof_o,
  output logic        usr_eof_o,
  output logic [31:0] usr_srcip_o,
  output logic [15:0] usr_srcport_o,
  output logic [15:0] usr_data_len_o,
  output logic        usr_good_o,
  output logic        usr_bad_o,
  output logic [15:0] stat_drop_o
);
  rx_state_t state, state_n;
  logic hi, byte_stb, pay_stb, hdr_fail, drop_inc, verdict_bad, er_seen, trunc, in_frame;
  logic [3:0] n0;
  logic [7:0] rx_byte;
  logic [15:0] cnt, ulen, plen, last_idx, srcport_s;
  logic [31:0] crc, crc_n, srcip_s;
  logic [39:0] sh;
  logic [47:0] win;

  eth_crc32_nibble u_crc (.crc_i(crc), .data_i(eth_rx_data), .crc_o(crc_n));

  // win holds the last six header bytes including the one completing now, so each
  // multi-byte field is checked as a whole on its final byte
  assign in_frame = state inside {HEADER, PAYLOAD, TAIL};
  assign rx_byte = {eth_rx_data, n0};
  assign win = {sh, rx_byte};
  assign plen = ulen - UDP_HDR_LEN;
  assign last_idx = ulen + HDR_TOTAL - UDP_HDR_LEN - 16'd1;

  always_ff @(posedge eth_rx_clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = !eth_rx_dv ? IDLE : eth_rx_data == 4'h5 ? PREAMBLE : DROP;
      PREAMBLE: state_n = !eth_rx_dv ? DROP : eth_rx_data == 4'h5 ? PREAMBLE :
                          eth_rx_data == 4'hD ? HEADER : DROP;
      HEADER: state_n = (!eth_rx_dv || eth_rx_er || (byte_stb && hdr_fail)) ? DROP :
                        (byte_stb && cnt == HDR_TOTAL - 16'd1) ? (ulen == UDP_HDR_LEN ? TAIL : PAYLOAD) :
                        HEADER;
      PAYLOAD: state_n = !eth_rx_dv ? CHECK : (byte_stb && cnt == last_idx) ? TAIL : PAYLOAD;
      TAIL: state_n = eth_rx_dv ? TAIL : CHECK;
      CHECK: state_n = IDLE;
      DROP: state_n = eth_rx_dv ? DROP : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    byte_stb = in_frame && eth_rx_dv && hi;
    pay_stb = state == PAYLOAD && byte_stb;
    drop_inc = state_n == DROP && state != DROP;
    verdict_bad = er_seen || hi || trunc || cnt < ulen + HDR_TOTAL - UDP_HDR_LEN + 16'd4 ||
                  crc != CRC32_RESIDUE;
    hdr_fail = (cnt == 16'd5 && win != cfg_ethaddr_i && !(ACCEPT_BCAST && &win)) ||
               (cnt == ETH_HDR_LEN - 16'd1 && win[15:0] != ETHERTYPE_IPV4) ||
               (cnt == ETH_HDR_LEN && rx_byte != 8'h45) ||
               (cnt == ETH_HDR_LEN + 16'd7 && win[13:0] != 14'd0) ||
               (cnt == ETH_HDR_LEN + 16'd9 && rx_byte != IP_PROTO_UDP) ||
               (cnt == ETH_HDR_LEN + 16'd19 && win[31:0] != cfg_ipaddr_i) ||
               (cnt == ETH_HDR_LEN + IP_HDR_LEN + 16'd3 && win[15:0] != cfg_udpport_i) ||
               (cnt == ETH_HDR_LEN + IP_HDR_LEN + 16'd5 &&
                (win[15:0] < UDP_HDR_LEN || win[15:0] > 16'(MAX_PAYLOAD) + UDP_HDR_LEN));
  end

  always_ff @(posedge eth_rx_clk or negedge reset_n)
    if (!reset_n) begin
      usr_data_o <= '0;
      usr_valid_o <= 1'b0;
      usr_sof_o <= 1'b0;
      usr_eof_o <= 1'b0;
      usr_srcip_o <= '0;
      usr_srcport_o <= '0;
      usr_data_len_o <= '0;
      usr_good_o <= 1'b0;
      usr_bad_o <= 1'b0;
      stat_drop_o <= '0;
      hi <= 1'b0;
      n0 <= '0;
      cnt <= '0;
      ulen <= '0;
      crc <= '1;
      sh <= '0;
      srcip_s <= '0;
      srcport_s <= '0;
      er_seen <= 1'b0;
      trunc <= 1'b0;
    end else begin
      usr_valid_o <= pay_stb;
      usr_sof_o <= pay_stb && cnt == HDR_TOTAL;
      usr_eof_o <= pay_stb && cnt == last_idx;
      usr_good_o <= state == CHECK && !verdict_bad;
      usr_bad_o <= state == CHECK && verdict_bad;
      if (pay_stb) usr_data_o <= rx_byte;
      if (drop_inc && stat_drop_o != 16'hFFFF) stat_drop_o <= stat_drop_o + 16'd1;
      if (state == PREAMBLE) begin
        hi <= 1'b0;
        cnt <= '0;
        crc <= '1;
        er_seen <= 1'b0;
        trunc <= 1'b0;
      end else if (in_frame && eth_rx_dv) begin
        crc <= crc_n;
        hi <= !hi;
        er_seen <= er_seen || eth_rx_er;
        if (!hi) n0 <= eth_rx_data;
        if (byte_stb) begin
          cnt <= cnt + 16'd1;
          sh <= win[39:0];
        end
        if (byte_stb && state == HEADER) begin
          if (cnt == ETH_HDR_LEN + 16'd15) srcip_s <= win[31:0];
          if (cnt == ETH_HDR_LEN + IP_HDR_LEN + 16'd1) srcport_s <= win[15:0];
          if (cnt == ETH_HDR_LEN + IP_HDR_LEN + 16'd5) ulen <= win[15:0];
          if (cnt == HDR_TOTAL - 16'd1) begin
            usr_srcip_o <= srcip_s;
            usr_srcport_o <= srcport_s;
            usr_data_len_o <= plen;
          end
        end
      end
      if (state == PAYLOAD && !eth_rx_dv) trunc <= 1'b1;
    end
endmodule

// File: tb/tb_eth_udprx.sv
// tb_eth_udprx: scoreboard bench for eth_udprx using independently built frames and FCS
module tb_eth_udprx;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] rx_data;
  logic rx_dv, rx_er;
  logic [7:0] usr_data_o;
  logic usr_valid_o, usr_sof_o, usr_eof_o, usr_good_o, usr_bad_o;
  logic [31:0] usr_srcip_o;
  logic [15:0] usr_srcport_o, usr_data_len_o, stat_drop_o;
  int checks = 0, passes = 0;
  logic [7:0] fr[$];
  logic [9:0] exp_q[$];
  logic [9:0] obs [0:1023];
  int obs_n = 0, good_cnt = 0, bad_cnt = 0, rd = 0;

  always #20 clk = ~clk;

  eth_udprx dut (
    .eth_rx_clk(clk), .reset_n(reset_n), .eth_rx_data(rx_data), .eth_rx_dv(rx_dv), .eth_rx_er(rx_er),
    .cfg_ethaddr_i(48'h000102030405), .cfg_ipaddr_i(32'hC0A8020A), .cfg_udpport_i(16'd4000),
    .usr_data_o(usr_data_o), .usr_valid_o(usr_valid_o), .usr_sof_o(usr_sof_o), .usr_eof_o(usr_eof_o),
    .usr_srcip_o(usr_srcip_o), .usr_srcport_o(usr_srcport_o), .usr_data_len_o(usr_data_len_o),
    .usr_good_o(usr_good_o), .usr_bad_o(usr_bad_o), .stat_drop_o(stat_drop_o)
  );

  // monitor: records delivered bytes as {sof, eof, data} and counts verdict pulses
  always @(negedge clk) begin
    if (usr_valid_o) begin
      obs[obs_n] <= {usr_sof_o, usr_eof_o, usr_data_o};
      obs_n <= obs_n + 1;
    end
    if (usr_good_o) good_cnt <= good_cnt + 1;
    if (usr_bad_o) bad_cnt <= bad_cnt + 1;
  end

  function automatic logic [31:0] fcs_of();
    logic [31:0] c;
    c = '1;
    foreach (fr[i]) begin
      c ^= {24'h0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_frame(input logic [15:0] dport, input logic [31:0] dip, input logic [15:0] etype,
                             input int plen, input logic [7:0] base);
    logic [15:0] tl, ul;
    logic [31:0] fcs;
    tl = 16'(28 + plen);
    ul = 16'(8 + plen);
    fr = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
          etype[15:8], etype[7:0], 8'h45, 8'h00, tl[15:8], tl[7:0], 8'h00, 8'h00, 8'h40, 8'h00,
          8'h40, 8'h11, 8'h00, 8'h00, 8'hC0, 8'hA8, 8'h02, 8'h01,
          dip[31:24], dip[23:16], dip[15:8], dip[7:0],
          8'h13, 8'h88, dport[15:8], dport[7:0], ul[15:8], ul[7:0], 8'h00, 8'h00};
    for (int i = 0; i < plen; i++) fr.push_back(base + 8'(i));
    while (fr.size() < 60) fr.push_back(8'h00);
    fcs = fcs_of();
    for (int b = 0; b < 4; b++) fr.push_back(fcs[8*b +: 8]);
  endtask

  task automatic push_exp(input int n, input int plen, input int flip);
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'(i == 0), 1'(i == plen - 1), fr[42+i] ^ ((42 + i == flip) ? 8'h01 : 8'h00)});
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    rx_dv = 1'b1;
    rx_data = n;
  endtask

  task automatic send_frame(input int nbytes, input int flip, input bit keep_dv);
    logic [7:0] b;
    for (int i = 0; i < 15; i++) nib(4'h5);
    nib(4'hD);
    for (int i = 0; i < nbytes; i++) begin
      b = fr[i] ^ ((i == flip) ? 8'h01 : 8'h00);
      nib(b[3:0]);
      nib(b[7:4]);
    end
    if (!keep_dv) begin
      @(negedge clk);
      rx_dv = 1'b0;
      rx_data = 4'h0;
      repeat (24) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({usr_valid_o, usr_sof_o, usr_eof_o, usr_good_o, usr_bad_o} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {usr_valid_o, usr_sof_o, usr_eof_o, usr_good_o, usr_bad_o});
    else passes++;
    checks++;
    if (usr_data_o !== 8'h00) $display("FAIL reset_data: got %h want 00", usr_data_o); else passes++;
    checks++;
    if ({usr_srcip_o, usr_srcport_o, usr_data_len_o} !== 64'h0)
      $display("FAIL reset_info: got %h want 0", {usr_srcip_o, usr_srcport_o, usr_data_len_o});
    else passes++;
    checks++;
    if (stat_drop_o !== 16'h0) $display("FAIL reset_drop: got %0d want 0", stat_drop_o); else passes++;
  endtask

  task automatic test_valid_frame();
    int g, bd;
    logic [9:0] e;
    g = good_cnt;
    bd = bad_cnt;
    build_frame(16'd4000, 32'hC0A8020A, 16'h0800, 64, 8'h00);
    push_exp(64, 64, -1);
    send_frame(fr.size(), -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n || obs[rd] !== e) $display("FAIL valid_byte%0d: got %h want %h", rd, obs[rd], e);
      else passes++;
      rd++;
    end
    checks++;
    if (obs_n !== rd) $display("FAIL valid_count: got %0d want %0d", obs_n, rd); else passes++;
    checks++;
    if (usr_srcip_o !== 32'hC0A80201) $display("FAIL valid_srcip: got %h want C0A80201", usr_srcip_o); else passes++;
    checks++;
    if (usr_srcport_o !== 16'h1388) $display("FAIL valid_srcport: got %h want 1388", usr_srcport_o); else passes++;
    checks++;
    if (usr_data_len_o !== 16'd64) $display("FAIL valid_len: got %0d want 64", usr_data_len_o); else passes++;
    checks++;
    if (good_cnt - g !== 1 || bad_cnt - bd !== 0)
      $display("FAIL valid_verdict: got good=%0d bad=%0d want good=1 bad=0", good_cnt - g, bad_cnt - bd);
    else passes++;
  endtask

  task automatic test_bad_fcs();
    int g, bd;
    logic [9:0] e;
    g = good_cnt;
    bd = bad_cnt;
    build_frame(16'd4000, 32'hC0A8020A, 16'h0800, 64, 8'h00);
    push_exp(64, 64, 47);
    send_frame(fr.size(), 47, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n || obs[rd] !== e) $display("FAIL badfcs_byte%0d: got %h want %h", rd, obs[rd], e);
      else passes++;
      rd++;
    end
    checks++;
    if (obs_n !== rd) $display("FAIL badfcs_count: got %0d want %0d", obs_n, rd); else passes++;
    checks++;
    if (good_cnt - g !== 0 || bad_cnt - bd !== 1)
      $display("FAIL badfcs_verdict: got good=%0d bad=%0d want good=0 bad=1", good_cnt - g, bad_cnt - bd);
    else passes++;
  endtask

  task automatic test_drops();
    int g, bd;
    g = good_cnt;
    bd = bad_cnt;
    for (int k = 0; k < 3; k++) begin
      build_frame(k == 0 ? 16'd4001 : 16'd4000, k == 1 ? 32'hC0A8020B : 32'hC0A8020A,
                  k == 2 ? 16'h0806 : 16'h0800, 64, 8'h00);
      send_frame(fr.size(), -1, 0);
      checks++;
      if (stat_drop_o !== 16'(k + 1)) $display("FAIL drop_count%0d: got %0d want %0d", k, stat_drop_o, k + 1);
      else passes++;
    end
    checks++;
    if (obs_n !== rd) $display("FAIL drop_valid: got %0d bytes want 0", obs_n - rd); else passes++;
    checks++;
    if (good_cnt - g + bad_cnt - bd !== 0) $display("FAIL drop_verdict: got %0d pulses want 0", good_cnt - g + bad_cnt - bd);
    else passes++;
  endtask

  task automatic test_min_payload();
    int g, bd;
    logic [9:0] e;
    g = good_cnt;
    bd = bad_cnt;
    build_frame(16'd4000, 32'hC0A8020A, 16'h0800, 1, 8'hA5);
    push_exp(1, 1, -1);
    send_frame(fr.size(), -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n || obs[rd] !== e) $display("FAIL min_byte: got %h want %h", obs[rd], e);
      else passes++;
      rd++;
    end
    checks++;
    if (obs_n !== rd) $display("FAIL min_count: got %0d want %0d", obs_n, rd); else passes++;
    checks++;
    if (usr_data_len_o !== 16'd1) $display("FAIL min_len: got %0d want 1", usr_data_len_o); else passes++;
    checks++;
    if (good_cnt - g !== 1 || bad_cnt - bd !== 0)
      $display("FAIL min_verdict: got good=%0d bad=%0d want good=1 bad=0", good_cnt - g, bad_cnt - bd);
    else passes++;
  endtask

  task automatic test_truncated();
    int g, bd;
    logic [9:0] e;
    g = good_cnt;
    bd = bad_cnt;
    build_frame(16'd4000, 32'hC0A8020A, 16'h0800, 64, 8'h00);
    push_exp(10, 64, -1);
    send_frame(52, -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n || obs[rd] !== e) $display("FAIL trunc_byte%0d: got %h want %h", rd, obs[rd], e);
      else passes++;
      rd++;
    end
    checks++;
    if (obs_n !== rd) $display("FAIL trunc_count: got %0d want %0d", obs_n, rd); else passes++;
    checks++;
    if (good_cnt - g !== 0 || bad_cnt - bd !== 1)
      $display("FAIL trunc_verdict: got good=%0d bad=%0d want good=0 bad=1", good_cnt - g, bad_cnt - bd);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    int g, bd;
    logic [9:0] e;
    g = good_cnt;
    bd = bad_cnt;
    build_frame(16'd4000, 32'hC0A8020A, 16'h0800, 64, 8'h00);
    push_exp(5, 64, -1);
    send_frame(47, -1, 1);
    @(negedge clk);
    #5 reset_n = 1'b0;
    #1;
    checks++;
    if ({usr_valid_o, usr_sof_o, usr_eof_o, usr_good_o, usr_bad_o} !== 5'b0 || usr_data_o !== 8'h00)
      $display("FAIL midreset_stream: got %b/%h want 0", {usr_valid_o, usr_sof_o, usr_eof_o, usr_good_o, usr_bad_o}, usr_data_o);
    else passes++;
    checks++;
    if ({usr_srcip_o, usr_srcport_o, usr_data_len_o, stat_drop_o} !== 80'h0)
      $display("FAIL midreset_info: got %h want 0", {usr_srcip_o, usr_srcport_o, usr_data_len_o, stat_drop_o});
    else passes++;
    rx_dv = 1'b0;
    rx_data = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (24) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n || obs[rd] !== e) $display("FAIL midreset_byte%0d: got %h want %h", rd, obs[rd], e);
      else passes++;
      rd++;
    end
    checks++;
    if (good_cnt - g + bad_cnt - bd !== 0) $display("FAIL midreset_verdict: got %0d pulses want 0", good_cnt - g + bad_cnt - bd);
    else passes++;
    g = good_cnt;
    bd = bad_cnt;
    push_exp(64, 64, -1);
    send_frame(fr.size(), -1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd >= obs_n || obs[rd] !== e) $display("FAIL after_byte%0d: got %h want %h", rd, obs[rd], e);
      else passes++;
      rd++;
    end
    checks++;
    if (obs_n !== rd) $display("FAIL after_count: got %0d want %0d", obs_n, rd); else passes++;
    checks++;
    if (good_cnt - g !== 1 || bad_cnt - bd !== 0)
      $display("FAIL after_verdict: got good=%0d bad=%0d want good=1 bad=0", good_cnt - g, bad_cnt - bd);
    else passes++;
  endtask

  initial begin
    reset_n = 1'b0;
    rx_dv = 1'b0;
    rx_er = 1'b0;
    rx_data = 4'h0;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    test_valid_frame();
    test_bad_fcs();
    test_drops();
    test_min_payload();
    test_truncated();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
